// File: rtl/complete_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// complete_arbiter_pkg : shared widths and packet types for the complete stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package complete_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int NUM_CPL_SRC    = 3;
  localparam int CPL_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      dest_reg_idx;
    logic [5:0]      rob_idx;
    logic            halt;
  } IS_EX_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    IS_EX_PACKET     ex;
  } CDB_PACKET;

  // One buffered FU result as held in a per-source FIFO slot
  typedef struct packed {
    logic [XLEN-1:0] result;
    IS_EX_PACKET     ex;
  } CPL_ENTRY;

endpackage

`default_nettype wire

// File: rtl/complete_arbiter_if.sv
// ----------------------------------------------------------------------------
// complete_arbiter_if : FU-result / CDB bundle between issue-execute and complete
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_CPL_SRC
) ();

  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 squash;
  logic [NUM_SRC-1:0]   src_done;
  logic [XLEN-1:0]      src_result [NUM_SRC];
  IS_EX_PACKET          src_packet [NUM_SRC];
  logic [NUM_SRC-1:0]   src_ready;
  CDB_PACKET            cdb_out;
  logic                 overflow;
  logic [RW-1:0]        rr_ptr;

  modport master (
    output squash, src_done, src_result, src_packet,
    input  src_ready, cdb_out, overflow, rr_ptr
  );

  modport slave (
    input  squash, src_done, src_result, src_packet,
    output src_ready, cdb_out, overflow, rr_ptr
  );

endinterface

`default_nettype wire

// File: rtl/complete_arbiter_result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo : per-source circular buffer of completed FU results
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module result_fifo
  import complete_arbiter_pkg::*;
#(
  parameter int DEPTH = CPL_FIFO_DEPTH,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  wire logic    clock,
  input  wire logic    reset,
  input  wire logic    clear_i,
  input  wire logic    push_i,
  input  CPL_ENTRY     push_data_i,
  input  wire logic    pop_i,
  output CPL_ENTRY     head_data_o,
  output logic [OW-1:0] occ_o
);

  CPL_ENTRY        mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [OW-1:0]   occ_q,  occ_d;
  logic            do_push, do_pop, full;

  always_comb begin
    full    = (occ_q == OW'(DEPTH));
    do_pop  = pop_i && (occ_q != '0);
    // A full FIFO still accepts a push when the head leaves the same cycle
    do_push = push_i && (!full || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    if (do_pop)
      head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
    if (do_push)
      tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
    occ_d = occ_q + OW'(do_push) - OW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !clear_i && do_push)
      mem_q[tail_q] <= push_data_i;
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

`default_nettype wire

// File: rtl/complete_arbiter.sv
// ----------------------------------------------------------------------------
// complete_arbiter : buffers FU results and round-robins them onto a registered CDB
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_CPL_SRC,
  parameter int DEPTH   = CPL_FIFO_DEPTH
) (
  input wire logic            clock,
  input wire logic            reset,
  complete_arbiter_if.slave   bus
);

  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW:0] READY_LIM = (OW+1)'(DEPTH - 2);

  CPL_ENTRY           head_data [NUM_SRC];
  CPL_ENTRY           push_data [NUM_SRC];
  logic [OW-1:0]      occ       [NUM_SRC];
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] ready;

  logic [RW-1:0]      rr_q, rr_d;
  CDB_PACKET          cdb_q, cdb_d;
  logic               ovf_q, ovf_d;

  logic               found;
  logic               grant_v;
  logic [RW-1:0]      grant_idx;
  logic [RW-1:0]      scan_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    assign push_data[i] = '{result: bus.src_result[i], ex: bus.src_packet[i]};

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (bus.squash),
      .push_i      (bus.src_done[i]),
      .push_data_i (push_data[i]),
      .pop_i       (pop[i]),
      .head_data_o (head_data[i]),
      .occ_o       (occ[i])
    );
  end

  // Ready leaves headroom for one result already in flight from an enabled FU
  always_comb begin
    ready = '0;
    full  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      full[i]  = (occ[i] == OW'(DEPTH));
      ready[i] = !reset &&
                 (({1'b0, occ[i]} + {{OW{1'b0}}, bus.src_done[i]}) <= READY_LIM);
    end
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = rr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && (occ[scan_idx] != '0)) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == RW'(NUM_SRC - 1)) ? '0 : scan_idx + RW'(1);
    end
    grant_v = found && !bus.squash;

    pop = '0;
    for (int i = 0; i < NUM_SRC; i++)
      pop[i] = grant_v && (grant_idx == RW'(i));

    rr_d = rr_q;
    if (grant_v)
      rr_d = (grant_idx == RW'(NUM_SRC - 1)) ? '0 : grant_idx + RW'(1);

    cdb_d        = '0;
    cdb_d.valid  = grant_v;
    cdb_d.result = head_data[grant_idx].result;
    cdb_d.ex     = head_data[grant_idx].ex;

    // A squashed push is discarded by design and is not an overflow
    ovf_d = ovf_q | (!bus.squash && |(bus.src_done & full & ~pop));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q  <= '0;
      cdb_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cdb_q <= cdb_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.src_ready = ready;
  assign bus.cdb_out   = cdb_q;
  assign bus.overflow  = ovf_q;
  assign bus.rr_ptr    = rr_q;

endmodule

`default_nettype wire

// File: tb/tb_complete_arbiter.sv
// ----------------------------------------------------------------------------
// tb_complete_arbiter : directed stimulus, queue-based reference model, literal pins
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int N = NUM_CPL_SRC;
  localparam int D = CPL_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  complete_arbiter_if #(.NUM_SRC(N)) bus ();

  complete_arbiter #(.NUM_SRC(N), .DEPTH(D)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  CPL_ENTRY  mq [N][$];
  int        m_rr;
  CDB_PACKET m_cdb;
  bit        m_ovf;

  IS_EX_PACKET exp_pkt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic IS_EX_PACKET mkpkt(input int s, input int tag);
    IS_EX_PACKET p;
    p.pc           = 32'h0001_0000 + 32'(tag) * 4;
    p.dest_reg_idx = 5'(s * 7 + tag);
    p.rob_idx      = 6'(tag);
    p.halt         = tag[0];
    return p;
  endfunction

  // Reference model: queues per source, round-robin scan, registered CDB slot
  always @(posedge clk) begin : p_model
    int g;
    CPL_ENTRY e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr  = 0;
      m_cdb = '0;
      m_ovf = 1'b0;
    end else if (bus.squash) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_cdb.valid = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      if (g >= 0) begin
        e     = mq[g].pop_front();
        m_cdb = '{valid: 1'b1, result: e.result, ex: e.ex};
        m_rr  = (g + 1) % N;
      end else begin
        m_cdb.valid = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (bus.src_done[i]) begin
          if (mq[i].size() < D) mq[i].push_back('{result: bus.src_result[i], ex: bus.src_packet[i]});
          else m_ovf = 1'b1;
        end
    end
  end

  always @(negedge clk) begin : p_compare
    logic [N-1:0] er;
    if (chk_en) begin
      for (int i = 0; i < N; i++)
        er[i] = !rst && ((mq[i].size() + int'(bus.src_done[i])) <= D - 2);
      chk("cdb_valid", 64'(bus.cdb_out.valid), 64'(m_cdb.valid));
      if (m_cdb.valid) begin
        chk("cdb_result", 64'(bus.cdb_out.result), 64'(m_cdb.result));
        chk("cdb_packet", 64'(bus.cdb_out.ex), 64'(m_cdb.ex));
      end
      chk("src_ready", 64'(bus.src_ready), 64'(er));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("rr_ptr", 64'(bus.rr_ptr), 64'(m_rr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [31:0] r, input int tag);
    bus.src_result[s] = r;
    bus.src_packet[s] = mkpkt(s, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.src_done = '0;
    bus.squash   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.squash   = 1'b0;
    bus.src_done = '0;
    for (int i = 0; i < N; i++) set_src(i, '0, 0);

    // Reset held two cycles, then idle
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("t1_ready", 64'(bus.src_ready), 64'h7);
    chk("t1_valid", 64'(bus.cdb_out.valid), 64'h0);
    chk("t1_ovf", 64'(bus.overflow), 64'h0);
    chk("t1_rr", 64'(bus.rr_ptr), 64'h0);
    tick();

    // Single ALU result, two-cycle latency
    set_src(0, 32'h0000_00AA, 5);
    exp_pkt = mkpkt(0, 5);
    bus.src_done = 3'b001;
    tick();
    bus.src_done = 3'b000;
    tick();
    chk("t2_valid", 64'(bus.cdb_out.valid), 64'h1);
    chk("t2_result", 64'(bus.cdb_out.result), 64'hAA);
    chk("t2_packet", 64'(bus.cdb_out.ex), 64'(exp_pkt));
    tick();
    chk("t2_valid_off", 64'(bus.cdb_out.valid), 64'h0);

    // All three sources at once from rr_ptr=0
    do_reset();
    set_src(0, 32'd1, 10);
    set_src(1, 32'd2, 11);
    set_src(2, 32'd3, 12);
    bus.src_done = 3'b111;
    tick();
    bus.src_done = 3'b000;
    tick();
    chk("t3_res0", 64'(bus.cdb_out.result), 64'd1);
    tick();
    chk("t3_res1", 64'(bus.cdb_out.result), 64'd2);
    tick();
    chk("t3_res2", 64'(bus.cdb_out.result), 64'd3);
    chk("t3_rr", 64'(bus.rr_ptr), 64'h0);
    tick();

    // ALU streams while MULT holds one entry: MULT served on the second grant
    set_src(0, 32'hA0, 20);
    set_src(2, 32'hC0, 21);
    bus.src_done = 3'b101;
    tick();
    set_src(0, 32'hA1, 22);
    bus.src_done = 3'b001;
    tick();
    chk("t4_alu_first", 64'(bus.cdb_out.result), 64'hA0);
    set_src(0, 32'hA2, 23);
    tick();
    chk("t4_mult_second", 64'(bus.cdb_out.result), 64'hC0);
    set_src(0, 32'hA3, 24);
    tick();
    bus.src_done = 3'b000;
    repeat (6) tick();

    // Backpressure, then a forced push into a full FIFO
    do_reset();
    set_src(0, 32'h50, 30);
    set_src(1, 32'h51, 31);
    set_src(2, 32'h52, 32);
    bus.src_done = 3'b111;
    #1;
    chk("t5_ready0_low", 64'(bus.src_ready[0]), 64'h0);
    tick();
    set_src(0, 32'h60, 33);
    set_src(1, 32'h61, 34);
    set_src(2, 32'h62, 35);
    tick();
    set_src(0, 32'h70, 36);
    set_src(1, 32'h71, 37);
    set_src(2, 32'h72, 38);
    tick();
    chk("t5_ovf_set", 64'(bus.overflow), 64'h1);
    bus.src_done = 3'b000;
    repeat (8) tick();
    chk("t5_ovf_sticky", 64'(bus.overflow), 64'h1);

    // Squash with three entries buffered and a concurrent push
    do_reset();
    set_src(0, 32'h80, 40);
    set_src(1, 32'h81, 41);
    set_src(2, 32'h82, 42);
    bus.src_done = 3'b111;
    tick();
    set_src(1, 32'h91, 43);
    bus.src_done = 3'b010;
    bus.squash   = 1'b1;
    tick();
    bus.src_done = 3'b000;
    bus.squash   = 1'b0;
    #1;
    chk("t6_valid", 64'(bus.cdb_out.valid), 64'h0);
    chk("t6_ready", 64'(bus.src_ready), 64'h7);
    tick();
    chk("t6_valid_next", 64'(bus.cdb_out.valid), 64'h0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
